// File: rtl/ultrasonido_ctrl.sv
// Ultrasonic range sequencer for an HC-SR04-style sensor.
// Fires the trigger pulse, times the echo in tick units (8-bit, saturating),
// hands the count to the external halving divider and latches its result.
module ultrasonido_ctrl #(
    parameter int TRIG_CYCLES = 500,
    parameter int TICK_CYCLES = 1450,
    parameter int WAIT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       echo,
    output logic       trigger,
    output logic [7:0] count,
    output logic       calculate,
    input  logic       div_done,
    input  logic [7:0] div_d,
    output logic [7:0] distance,
    output logic       valid,
    output logic       busy,
    output logic       timeout
);

    // One counter serves both the trigger pulse and the echo wait window.
    localparam int CYC_MAX = (WAIT_CYCLES > TRIG_CYCLES) ? WAIT_CYCLES : TRIG_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int TICK_W  = $clog2(TICK_CYCLES + 1);

    localparam logic [CYC_W-1:0]  CYC_ZERO  = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1'b1);
    localparam logic [CYC_W-1:0]  TRIG_LAST = CYC_W'(TRIG_CYCLES - 1);
    localparam logic [CYC_W-1:0]  WAIT_LAST = CYC_W'(WAIT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1'b1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        CALC      = 3'd4,
        DONE_ST   = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic                sync1_r, sync2_r;
    logic                echo_s;
    logic [CYC_W-1:0]    cyc_r, cyc_s;
    logic [TICK_W-1:0]   tick_r, tick_s;
    logic [7:0]          count_r, count_s;
    logic [7:0]          distance_r, distance_s;
    logic                trigger_r, trigger_s;
    logic                calculate_r, calculate_s;
    logic                valid_r, valid_s;
    logic                busy_r, busy_s;
    logic                timeout_r, timeout_s;

    assign echo_s = sync2_r;

    // Two-flop synchronizer for the asynchronous echo pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= echo;
            sync2_r <= sync1_r;
        end
    end

    // Next-state and next-output logic for the measurement sequence.
    always_comb begin
        state_s     = state_r;
        cyc_s       = cyc_r;
        tick_s      = tick_r;
        count_s     = count_r;
        trigger_s   = trigger_r;
        calculate_s = calculate_r;
        distance_s  = distance_r;
        valid_s     = 1'b0;
        timeout_s   = timeout_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = TRIG;
                    cyc_s     = CYC_ZERO;
                    count_s   = 8'd0;
                    timeout_s = 1'b0;
                    trigger_s = 1'b1;
                end else begin
                    trigger_s = 1'b0;
                end
            end
            TRIG: begin
                if (cyc_r == TRIG_LAST) begin
                    trigger_s = 1'b0;
                    state_s   = WAIT_ECHO;
                    cyc_s     = CYC_ZERO;
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            WAIT_ECHO: begin
                if (echo_s) begin
                    state_s = MEASURE;
                    tick_s  = TICK_ZERO;
                    count_s = 8'd0;
                end else if (cyc_r == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            MEASURE: begin
                // The exit cycle is still counted; any partial tick is dropped.
                if (tick_r == TICK_LAST) begin
                    tick_s = TICK_ZERO;
                    if (count_r != 8'hFF) begin
                        count_s = count_r + 8'd1;
                    end else begin
                        count_s = count_r;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
                if (count_s == 8'hFF) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = timeout_r;
                end
                if (!echo_s) begin
                    state_s     = CALC;
                    calculate_s = 1'b1;
                end else begin
                    state_s = MEASURE;
                end
            end
            CALC: begin
                calculate_s = 1'b1;
                if (div_done) begin
                    distance_s  = div_d;
                    valid_s     = 1'b1;
                    calculate_s = 1'b0;
                    state_s     = DONE_ST;
                end else begin
                    state_s = CALC;
                end
            end
            DONE_ST: begin
                calculate_s = 1'b0;
                state_s     = IDLE;
            end
            default: begin
                state_s     = IDLE;
                trigger_s   = 1'b0;
                calculate_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cyc_r       <= CYC_ZERO;
            tick_r      <= TICK_ZERO;
            count_r     <= 8'd0;
            distance_r  <= 8'd0;
            trigger_r   <= 1'b0;
            calculate_r <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cyc_r       <= cyc_s;
            tick_r      <= tick_s;
            count_r     <= count_s;
            distance_r  <= distance_s;
            trigger_r   <= trigger_s;
            calculate_r <= calculate_s;
            valid_r     <= valid_s;
            busy_r      <= busy_s;
            timeout_r   <= timeout_s;
        end
    end

    assign trigger   = trigger_r;
    assign count     = count_r;
    assign calculate = calculate_r;
    assign distance  = distance_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule
